cmult_rr_arbiter: RTL and testbench
===================================

Name: cmult_rr_arbiter

Overview:
Shares one complex_mult datapath (16-bit data × 12-bit Q1.10 twiddle, round-half-up, >>10) among N_REQ requesters, e.g. parallel butterfly lanes or a window/twiddle stage.
- Per-requester valid/ready handshake; round-robin grant.
- Two-register pipeline around the multiplier, tagged with the requester ID.
- One result port with backpressure.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, requester ID width; equals clog2(N_REQ), minimum 1

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
req_valid  in  N_REQ  per-requester operand valid
req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle
req_re  in  N_REQ*16  signed data Re; requester k at [16k+:16]
req_im  in  N_REQ*16  signed data Im
req_tw_re  in  N_REQ*12  signed twiddle Re, Q1.10; requester k at [12k+:12]
req_tw_im  in  N_REQ*12  signed twiddle Im, Q1.10
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_re  out  16  product Re, same format as complex_mult Re_out
out_im  out  16  product Im
out_id  out  ID_W  index of the requester that issued the result
busy  out  1  either pipeline stage holds valid data

Behaviour:
- Transfer on req_valid[k] && req_ready[k]. Output transfer on out_valid && out_ready.
- Pipeline stages:
  - S1: registered operands + id + v1.
  - S2: registered complex_mult outputs + id + v2. S2 drives out_*.
- Stage enables, which collapse bubbles:
  - en2 = !v2 || out_ready.
  - en1 = !v1 || en2.
- Arbitration, combinational:
  - Search req_valid starting at (last+1) mod N_REQ. The first set bit is the grant g.
  - req_ready[g] = en1; all other req_ready bits = 0.
  - req_ready may depend on out_ready combinationally. Requesters must not make req_valid depend on req_ready.
- Pointer update: `last` updates to g only on an accepted transfer. It does not move while stalled, so a stalled grant is held. This guarantees no starvation: every asserted requester is served within N_REQ accepted transfers.
- When en1 is high:
  - v1 <= any accepted transfer.
  - S1 data loads only on a transfer; it holds otherwise.
- When en2 is high:
  - v2 <= v1.
  - S2 data loads from complex_mult(S1) when v1 is set.
- Latency:
  - Accept at cycle n gives out_valid at n+2 when there is no backpressure.
  - Throughput is 1 result per cycle.
- Backpressure:
  - While out_valid && !out_ready, out_re/out_im/out_id hold stable.
  - S1 still accepts one more transfer if v1 = 0.
  - Then all req_ready bits drop.
- Arithmetic is bit-exact with complex_mult:
  - Re = (a·c − b·d + 512)[25:10].
  - Im = (a·d + c·b + 512)[25:10].
  - Full 28-bit signed intermediate; truncation wraps, no saturation.
- Reset (synchronous):
  - v1 = v2 = 0, and all S1/S2 data and id = 0, so out_* = 0.
  - last = N_REQ−1, so requester 0 has first priority.
  - req_ready = 0 during rst.
  - Reset mid-operation discards in-flight results silently.
- Values of req_* on requesters without req_ready are ignored.
- busy = v1 || v2.

Decomposition:
- Package cmult_pkg holds constants DATA_W=16, TW_W=12, FRAC_W=10, ROUND_C=512, and a function clog2.
- Sub-module rr_arbiter (N_REQ):
  - Inputs: req, advance.
  - Outputs: one-hot grant, grant index.
  - Holds the `last` pointer.
- complex_mult is instantiated unchanged between S1 and S2.

Test Plan:
- Single request: req 0 sends re=1000, im=0, tw=(1024,0) with out_ready=1. Expect out_valid exactly 2 cycles later with (1000,0) and id=0.
- Rounding, negative: req 2 sends (100,200) × tw (0,−1024). Expect out=(200,−100) and id=2, where Im = floor(−101888/1024).
- Fairness: all 4 requesters hold valid continuously for 12 accepts. Expect ids 0,1,2,3,0,1,2,3,… and each req_ready asserted exactly 3 times.
- Backpressure: stream from req 1, then hold out_ready=0 for 5 cycles. Expect out_* stable, exactly one extra accept, then all req_ready=0. On release, results arrive in order with none lost or duplicated.
- Bubbles: alternate valid on/off on req 3 with out_ready=1. Expect results 2 cycles after each accept, busy dropping when empty, and `last` unchanged on idle cycles.
- Reset mid-stream: assert rst with v1=v2=1. Expect out_valid=0, out_*=0 and req_ready=0 the next cycle. After release, req 0 gets first grant when all requesters are valid.

Source files
------------

// File: rtl/cmult_pkg.sv
// Shared constants for the complex multiplier and its round-robin front end.
//   DATA_W  : width of the complex data samples (signed)
//   TW_W    : width of the twiddle factors (signed Q1.10)
//   FRAC_W  : number of fractional twiddle bits dropped after the product
//   ROUND_C : half-LSB constant added before truncation (round half up)
//   PROD_W  : width of the full signed product/sum intermediate
//   clog2() : ceiling log2, never below 1 so a 1-bit ID always exists
package cmult_pkg;

  localparam int DATA_W  = 16;
  localparam int TW_W    = 12;
  localparam int FRAC_W  = 10;
  localparam int ROUND_C = 512;
  localparam int PROD_W  = DATA_W + TW_W;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/complex_mult.sv
// Combinational complex multiply of a 16-bit data sample by a Q1.10 twiddle,
// rounded half up and scaled back down by 2^10.
//   re_in, im_in  : signed data sample
//   tw_re, tw_im  : signed twiddle, Q1.10
//   re_out        : (re*tw_re - im*tw_im + 512) bits [25:10]
//   im_out        : (re*tw_im + tw_re*im + 512) bits [25:10]
// The top bits of the 28-bit sum are simply dropped, so overflow wraps.
module complex_mult
  import cmult_pkg::*;
(
  input  logic [DATA_W-1:0] re_in,
  input  logic [DATA_W-1:0] im_in,
  input  logic [TW_W-1:0]   tw_re,
  input  logic [TW_W-1:0]   tw_im,
  output logic [DATA_W-1:0] re_out,
  output logic [DATA_W-1:0] im_out
);

  logic signed [PROD_W-1:0] a, b, c, d;
  logic signed [PROD_W-1:0] re_full, im_full;
  logic                     unused_bits;

  // Sign-extend every operand to the full product width first so the
  // multiply and the rounding add are done in one signed 28-bit context.
  assign a = PROD_W'($signed(re_in));
  assign b = PROD_W'($signed(im_in));
  assign c = PROD_W'($signed(tw_re));
  assign d = PROD_W'($signed(tw_im));

  assign re_full = a * c - b * d + PROD_W'(ROUND_C);
  assign im_full = a * d + c * b + PROD_W'(ROUND_C);

  assign re_out = re_full[FRAC_W +: DATA_W];
  assign im_out = im_full[FRAC_W +: DATA_W];

  // Guard and fraction bits are intentionally discarded.
  assign unused_bits = ^{re_full[PROD_W-1 -: 2], re_full[FRAC_W-1:0],
                         im_full[PROD_W-1 -: 2], im_full[FRAC_W-1:0]};

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a sticky grant.
//   clk, rst   : clock and synchronous active-high reset
//   req        : request vector, one bit per requester
//   advance    : high when the current grant was actually accepted
//   grant      : one-hot grant (all zero when nobody requests)
//   grant_idx  : index of the granted requester
// The pointer only moves on advance, so a stalled grant stays put and
// every requester is reached within N_REQ accepted transfers.
module rr_arbiter
  import cmult_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx
);

  logic [ID_W-1:0] last;
  logic [ID_W-1:0] cand;
  logic            found;

  // Scan the requesters starting just after the last winner and take the
  // first one that is asking.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = ID_W'((int'(last) + i) % N_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Reset to the highest index so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= ID_W'(N_REQ - 1);
    end else if (advance) begin
      last <= grant_idx;
    end
  end

endmodule

// File: rtl/cmult_rr_arbiter.sv
// Shares one complex_mult among N_REQ requesters with a round-robin grant
// and a two-stage, ID-tagged pipeline feeding a single backpressured port.
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester handshake (one ready at a time)
//   req_re, req_im        : per-requester data, 16 bits per lane
//   req_tw_re, req_tw_im  : per-requester twiddle, 12 bits per lane
//   out_valid/out_ready   : result handshake
//   out_re, out_im        : rounded complex product
//   out_id                : requester that issued the result
//   busy                  : either pipeline stage holds data
module cmult_rr_arbiter
  import cmult_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_re,
  input  logic [N_REQ*DATA_W-1:0] req_im,
  input  logic [N_REQ*TW_W-1:0]   req_tw_re,
  input  logic [N_REQ*TW_W-1:0]   req_tw_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_re,
  output logic [DATA_W-1:0]       out_im,
  output logic [ID_W-1:0]         out_id,
  output logic                    busy
);

  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_idx;
  logic              en1, en2, xfer;

  logic [DATA_W-1:0] sel_re, sel_im;
  logic [TW_W-1:0]   sel_tw_re, sel_tw_im;

  logic              v1, v2;
  logic [DATA_W-1:0] s1_re, s1_im;
  logic [TW_W-1:0]   s1_tw_re, s1_tw_im;
  logic [ID_W-1:0]   s1_id;
  logic [DATA_W-1:0] mult_re, mult_im;
  logic [DATA_W-1:0] s2_re, s2_im;
  logic [ID_W-1:0]   s2_id;

  // A stage may load when it is empty or the stage after it is moving,
  // which lets the pipeline squeeze out bubbles under backpressure.
  assign en2 = !v2 || out_ready;
  assign en1 = !v1 || en2;

  assign req_ready = rst ? '0 : (en1 ? grant : '0);
  assign xfer      = |(req_valid & req_ready);

  rr_arbiter #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req_valid),
    .advance  (xfer),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_re    = '0;
    sel_im    = '0;
    sel_tw_re = '0;
    sel_tw_im = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        sel_re    = req_re[k*DATA_W +: DATA_W];
        sel_im    = req_im[k*DATA_W +: DATA_W];
        sel_tw_re = req_tw_re[k*TW_W +: TW_W];
        sel_tw_im = req_tw_im[k*TW_W +: TW_W];
      end
    end
  end

  // Stage 1: operands are captured only on a real transfer and held
  // otherwise; the valid bit follows whether a transfer happened.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      s1_re    <= '0;
      s1_im    <= '0;
      s1_tw_re <= '0;
      s1_tw_im <= '0;
      s1_id    <= '0;
    end else if (en1) begin
      v1 <= xfer;
      if (xfer) begin
        s1_re    <= sel_re;
        s1_im    <= sel_im;
        s1_tw_re <= sel_tw_re;
        s1_tw_im <= sel_tw_im;
        s1_id    <= grant_idx;
      end
    end
  end

  complex_mult u_mult (
    .re_in (s1_re),
    .im_in (s1_im),
    .tw_re (s1_tw_re),
    .tw_im (s1_tw_im),
    .re_out(mult_re),
    .im_out(mult_im)
  );

  // Stage 2: registered product; holds its data while stalled so the
  // output stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2    <= 1'b0;
      s2_re <= '0;
      s2_im <= '0;
      s2_id <= '0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        s2_re <= mult_re;
        s2_im <= mult_im;
        s2_id <= s1_id;
      end
    end
  end

  assign out_valid = v2;
  assign out_re    = s2_re;
  assign out_im    = s2_im;
  assign out_id    = s2_id;
  assign busy      = v1 || v2;

endmodule

// File: tb/tb_cmult_rr_arbiter.sv
// Self-checking bench for cmult_rr_arbiter (N_REQ = 4). A behavioural model
// tracks the fair-arbitration pointer and an in-flight result queue.
module tb_cmult_rr_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*16-1:0] req_re, req_im;
  logic [N*12-1:0] req_tw_re, req_tw_im;
  logic          out_valid, out_ready;
  logic [15:0]   out_re, out_im;
  logic [1:0]    out_id;
  logic          busy;

  always #5 clk = ~clk;

  cmult_rr_arbiter #(.N_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_re(req_re), .req_im(req_im),
    .req_tw_re(req_tw_re), .req_tw_im(req_tw_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_id(out_id),
    .busy(busy)
  );

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic [1:0]  id;
    int          t;
  } item_t;

  item_t q[$];
  int    m_last = N - 1;
  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;

  // Round half up and keep 16 bits of the scaled value.
  function automatic logic [15:0] ref_round(input longint s);
    longint v;
    v = (s + 512) >>> 10;
    return v[15:0];
  endfunction

  function automatic int lane16(input logic [N*16-1:0] bus, input int k);
    return int'($signed(bus[k*16 +: 16]));
  endfunction

  function automatic int lane12(input logic [N*12-1:0] bus, input int k);
    return int'($signed(bus[k*12 +: 12]));
  endfunction

  function automatic int exp_grant();
    for (int i = 1; i <= N; i++) begin
      if (req_valid[(m_last + i) % N]) return (m_last + i) % N;
    end
    return -1;
  endfunction

  // Two results can be in flight; a third is only taken if one leaves.
  function automatic logic [N-1:0] exp_ready();
    int g;
    if (rst) return '0;
    g = exp_grant();
    if (g < 0) return '0;
    if (q.size() >= 2 && !out_ready) return '0;
    return N'(1 << g);
  endfunction

  function automatic bit exp_valid();
    return (q.size() > 0) && (cyc - q[0].t >= 2);
  endfunction

  function automatic void model_edge();
    logic [N-1:0] r;
    bit           pop;
    int           g, a, b, c, d;
    item_t        it;
    r   = exp_ready();
    pop = exp_valid() && out_ready;
    if (rst) begin
      q.delete();
      m_last = N - 1;
    end else begin
      if (pop) q.delete(0);
      if (r != '0) begin
        g = exp_grant();
        a = lane16(req_re, g);
        b = lane16(req_im, g);
        c = lane12(req_tw_re, g);
        d = lane12(req_tw_im, g);
        it.re = ref_round(longint'(a) * c - longint'(b) * d);
        it.im = ref_round(longint'(a) * d + longint'(c) * b);
        it.id = 2'(g);
        it.t  = cyc;
        q.push_back(it);
        m_last = g;
      end
    end
    cyc++;
  endfunction

  task automatic tick();
    @(negedge clk);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int k = 0; k < N; k++) begin
      req_re[k*16 +: 16]    = 16'($urandom());
      req_im[k*16 +: 16]    = 16'($urandom());
      req_tw_re[k*12 +: 12] = 12'($urandom());
      req_tw_im[k*12 +: 12] = 12'($urandom());
    end
  endtask

  task automatic set_lane(input int k, input int re, input int im, input int twr, input int twi);
    req_re[k*16 +: 16]    = 16'(re);
    req_im[k*16 +: 16]    = 16'(im);
    req_tw_re[k*12 +: 12] = 12'(twr);
    req_tw_im[k*12 +: 12] = 12'(twi);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    out_ready = 1'b1;
    rand_data();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready);
      end
      tick();
    end
    rst = 1'b0;
    req_valid = '0;
    #1;
    checks++;
    if ({out_valid, out_re, out_im, out_id, busy} !== 36'd0) begin
      errors++;
      $display("[TB] FAIL reset_out: got v=%b re=%h im=%h id=%0d busy=%b expected all zero",
               out_valid, out_re, out_im, out_id, busy);
    end
    tick();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    req_valid = 4'b0001;
    set_lane(0, 1000, 0, 1024, 0);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL single_ready: got %b expected 0001", req_ready);
    end
    tick();
    req_valid = '0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_early: out_valid got %b expected 0", out_valid);
    end
    tick();
    #1;
    checks++;
    if ({out_valid, out_re, out_im, out_id} !== {1'b1, 16'd1000, 16'd0, 2'd0}) begin
      errors++;
      $display("[TB] FAIL single_result: got v=%b re=%0d im=%0d id=%0d expected v=1 re=1000 im=0 id=0",
               out_valid, $signed(out_re), $signed(out_im), out_id);
    end
    tick();
    #1;
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL single_empty: got v=%b busy=%b expected 0 0", out_valid, busy);
    end
  endtask

  task automatic test_rounding();
    out_ready = 1'b1;
    req_valid = 4'b0100;
    set_lane(2, 100, 200, 0, -1024);
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL round_ready: got %b expected 0100", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    #1;
    checks++;
    if ({out_valid, out_re, out_im, out_id} !== {1'b1, 16'd200, 16'hFF9C, 2'd2}) begin
      errors++;
      $display("[TB] FAIL round_result: got v=%b re=%0d im=%0d id=%0d expected v=1 re=200 im=-100 id=2",
               out_valid, $signed(out_re), $signed(out_im), out_id);
    end
    tick();
    tick();
  endtask

  task automatic test_fairness();
    int cnt[N];
    int expid;
    for (int k = 0; k < N; k++) cnt[k] = 0;
    expid = (m_last + 1) % N;
    out_ready = 1'b1;
    req_valid = '1;
    for (int i = 0; i < 12; i++) begin
      rand_data();
      #1;
      checks++;
      if (req_ready !== N'(1 << expid)) begin
        errors++;
        $display("[TB] FAIL fair_grant: got %b expected one-hot id %0d", req_ready, expid);
      end
      if (exp_valid()) begin
        checks++;
        if ({out_valid, out_re, out_im, out_id} !== {1'b1, q[0].re, q[0].im, q[0].id}) begin
          errors++;
          $display("[TB] FAIL fair_out: got v=%b %h %h id=%0d expected %h %h id=%0d",
                   out_valid, out_re, out_im, out_id, q[0].re, q[0].im, q[0].id);
        end
      end
      for (int k = 0; k < N; k++) cnt[k] += int'(req_ready[k]);
      expid = (expid + 1) % N;
      tick();
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (cnt[k] != 3) begin
        errors++;
        $display("[TB] FAIL fair_count: requester %0d granted %0d times expected 3", k, cnt[k]);
      end
    end
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (out_valid !== exp_valid() || (exp_valid() && {out_re, out_im, out_id} !== {q[0].re, q[0].im, q[0].id})) begin
        errors++;
        $display("[TB] FAIL fair_drain: got v=%b %h %h id=%0d expected v=%b", out_valid, out_re, out_im, out_id, exp_valid());
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int accepts;
    int got;
    out_ready = 1'b1;
    req_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      #1;
      checks++;
      if (req_ready !== exp_ready()) begin
        errors++;
        $display("[TB] FAIL bp_stream_ready: got %b expected %b", req_ready, exp_ready());
      end
      tick();
    end
    req_valid = '0;
    tick();
    accepts = 0;
    req_valid = 4'b0010;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      #1;
      checks++;
      if (req_ready !== exp_ready()) begin
        errors++;
        $display("[TB] FAIL bp_ready: got %b expected %b", req_ready, exp_ready());
      end
      checks++;
      if (q.size() == 0 || {out_valid, out_re, out_im, out_id} !== {1'b1, q[0].re, q[0].im, q[0].id}) begin
        errors++;
        $display("[TB] FAIL bp_hold: got v=%b %h %h id=%0d", out_valid, out_re, out_im, out_id);
      end
      accepts += int'(|req_ready);
      tick();
    end
    checks++;
    if (accepts != 1) begin
      errors++;
      $display("[TB] FAIL bp_extra: got %0d accepts during stall expected 1", accepts);
    end
    req_valid = '0;
    out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (out_valid !== exp_valid() || (exp_valid() && {out_re, out_im, out_id} !== {q[0].re, q[0].im, q[0].id})) begin
        errors++;
        $display("[TB] FAIL bp_drain: got v=%b %h %h id=%0d expected v=%b", out_valid, out_re, out_im, out_id, exp_valid());
      end
      got += int'(out_valid === 1'b1);
      tick();
    end
    checks++;
    if (got != 2) begin
      errors++;
      $display("[TB] FAIL bp_drain_count: got %0d results expected 2", got);
    end
  endtask

  task automatic test_bubbles();
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      req_valid = (i < 10 && i % 2 == 0) ? 4'b1000 : 4'b0000;
      rand_data();
      #1;
      checks++;
      if (req_ready !== exp_ready()) begin
        errors++;
        $display("[TB] FAIL bubble_ready: got %b expected %b", req_ready, exp_ready());
      end
      checks++;
      if (out_valid !== exp_valid() || busy !== (q.size() > 0)) begin
        errors++;
        $display("[TB] FAIL bubble_state: got v=%b busy=%b expected v=%b busy=%b",
                 out_valid, busy, exp_valid(), q.size() > 0);
      end
      if (exp_valid()) begin
        checks++;
        if ({out_re, out_im, out_id} !== {q[0].re, q[0].im, q[0].id}) begin
          errors++;
          $display("[TB] FAIL bubble_out: got %h %h id=%0d expected %h %h id=%0d",
                   out_re, out_im, out_id, q[0].re, q[0].im, q[0].id);
        end
      end
      tick();
    end
    req_valid = '1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL bubble_last: got %b expected 0001", req_ready);
    end
    req_valid = '0;
    #1;
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    req_valid = '1;
    rand_data();
    tick();
    rand_data();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL rst_mid_ready: got %b expected 0000", req_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_re, out_im, out_id, busy} !== 36'd0) begin
      errors++;
      $display("[TB] FAIL rst_mid_out: got v=%b re=%h im=%h id=%0d busy=%b expected all zero",
               out_valid, out_re, out_im, out_id, busy);
    end
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL rst_mid_first: got %b expected 0001", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 79) == 0);
      req_valid = N'($urandom());
      out_ready = ($urandom_range(0, 9) < 7);
      rand_data();
      #1;
      checks++;
      if (req_ready !== exp_ready()) begin
        errors++;
        $display("[TB] FAIL rand_ready: cycle %0d got %b expected %b", cyc, req_ready, exp_ready());
      end
      checks++;
      if (out_valid !== exp_valid() || busy !== (q.size() > 0)) begin
        errors++;
        $display("[TB] FAIL rand_state: cycle %0d got v=%b busy=%b expected v=%b busy=%b",
                 cyc, out_valid, busy, exp_valid(), q.size() > 0);
      end
      if (exp_valid()) begin
        checks++;
        if ({out_re, out_im, out_id} !== {q[0].re, q[0].im, q[0].id}) begin
          errors++;
          $display("[TB] FAIL rand_out: cycle %0d got %h %h id=%0d expected %h %h id=%0d",
                   cyc, out_re, out_im, out_id, q[0].re, q[0].im, q[0].id);
        end
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    out_ready = 1'b1;
    req_re    = '0;
    req_im    = '0;
    req_tw_re = '0;
    req_tw_im = '0;
    @(posedge clk);
    #1;
    $display("[TB] starting cmult_rr_arbiter bench");
    test_reset();
    test_single();
    test_rounding();
    test_fairness();
    test_backpressure();
    test_bubbles();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
